gf180mcu_fd_sc_mcu7t5v0__nrzi_rx8: RTL and testbench
====================================================

// Module: gf180mcu_fd_sc_mcu7t5v0__nrzi_rx8
// PURPOSE
//   Serial receive end of the library's NRZI line macro: samples a single-ended NRZI line and
//   decodes it (no transition = 1, transition = 0). Removes stuffed bits and reports stuff errors.
//   Deserialises LSB-first into WIDTH-bit words with a one-cycle valid strobe.
//   Sits between a line input pad and a byte-wide consumer; consumes the stream a transmit-side
//   encoder produces.
// PARAMETERS
//   WIDTH      8   output word width in bits, >= 2
//   STUFF_LEN  6   consecutive decoded 1s after which the next decoded bit must be a stuffed 0
//   IDLE_LVL   1   line level assumed before the first sample; reloaded on reset
// PORTS
//   CLK   input   1      clock; all state updates on its rising edge
//   RST   input   1      synchronous, active-high reset
//   EN    input   1      sample strobe; I is sampled only when EN=1
//   I     input   1      NRZI line, already synchronised to CLK
//   CLR   input   1      synchronous framing clear (realign to word boundary)
//   Q     output  WIDTH  last completed word, LSB = first received bit
//   VLD   output  1      one-cycle pulse: Q holds a new word
//   ERR   output  1      one-cycle pulse: stuff violation detected
//   VDD   inout   1      supply
//   VSS   inout   1      ground
// BEHAVIOUR
//   - Reset (RST=1 at edge): prev=IDLE_LVL, ones=0, bitcnt=0, shreg=0, Q=0, VLD=0, ERR=0.
//     RST overrides EN and CLR. A partial word in flight at reset is discarded.
//   - Decode at each EN=1 edge: d = ~(I ^ prev); prev <= I.
//   - EN=0: no state change except VLD/ERR returning to 0.
//   - Unstuff: ones counts consecutive decoded 1s, range 0..STUFF_LEN.
//     * ones<STUFF_LEN: accept d; ones <= d ? ones+1 : 0.
//     * ones==STUFF_LEN, d=0: bit dropped silently, ones<=0, bitcnt unchanged.
//     * ones==STUFF_LEN, d=1: ERR=1 next cycle; ones<=0, bitcnt<=0, shreg<=0; bit dropped.
//   - Deserialise: accepted bit goes into shreg[bitcnt]; bitcnt increments.
//     * When bitcnt==WIDTH-1 and a bit is accepted: Q <= completed word, VLD=1 for the following
//       cycle, bitcnt<=0, shreg<=0.
//     * Latency: Q/VLD update at the same edge that samples the word's last bit.
//     * Q holds until the next completion or reset.
//   - No backpressure. Words complete at most once per WIDTH EN pulses, so VLD never occurs on
//     two consecutive cycles.
//   - CLR=1 (RST=0): bitcnt<=0, shreg<=0, ones<=0.
//     * If EN=1 in the same cycle, prev<=I still updates and the decoded bit is discarded.
//     * Q is unchanged. VLD and ERR are 0 the next cycle.
//   - ERR and VLD never assert together. A violation occurring on what would be the last bit
//     yields ERR only.
// STRUCTURE
//   - Package gf180mcu_fd_sc_mcu7t5v0__nrzi_pkg: STUFF_LEN/IDLE_LVL defaults, clog2 helpers for
//     the ones and bitcnt widths. Shared with the transmit-side encoder.
//   - Sub-module gf180mcu_fd_sc_mcu7t5v0__nrzi_unstuff: prev/ones state; outputs bit, bit_ok,
//     stuff_err.
//   - Top level: shift register, bitcnt, Q/VLD/ERR registers.
//   - Supply pins are carried through; no functional use.
// TESTING
//   1 Reset: RST=1 for 2 cycles, any I/EN -> Q=0x00, VLD=0, ERR=0 the cycle after release.
//   2 Zero word: after reset, I toggles on each of 8 EN pulses (0,1,0,1,...)
//     -> Q=0x00, VLD pulses once after the 8th sample.
//   3 Stuff removal: decoded 1,1,1,1,1,1, stuffed 0, then 0,0 (9 EN pulses)
//     -> Q=0x3F, VLD only after the 9th sample, ERR=0.
//   4 Violation: I held at 1 for 7 EN pulses from reset -> ERR pulses after the 7th sample, no VLD.
//     Next 8 decoded bits form 0xA5 -> Q=0xA5.
//   5 EN gaps: 0xA5 stream with 3 idle cycles (EN=0) between every sample
//     -> Q=0xA5 with one VLD pulse. Q/VLD unaffected during gaps.
//   6 Mid-word abort: 4 bits then RST (and separately CLR) for 1 cycle, then 0x5A
//     -> Q=0x5A, one VLD pulse, no word built from the stale bits.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nrzi_pkg.sv
// Shared definitions for the NRZI line macro (receive and transmit sides).
// Holds the default stuffing run length, the idle line level and helpers
// that size the run-length counter and the bit counter.
package gf180mcu_fd_sc_mcu7t5v0__nrzi_pkg;

  localparam int unsigned STUFF_LEN_DEF = 32'd6;
  localparam logic        IDLE_LVL_DEF  = 1'b1;

  // Number of bits needed to hold every value in 0..max_val (at least 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 32'd1;
    for (int unsigned k = 32'd1; k < 32'd31; k++) begin
      if ((32'd1 << k) <= max_val) begin
        w = k + 32'd1;
      end
    end
    return w;
  endfunction

  // Width of the consecutive-ones counter (range 0..stuff_len).
  function automatic int unsigned ones_width(input int unsigned stuff_len);
    return cnt_width(stuff_len);
  endfunction

  // Width of the word bit counter (range 0..width-1).
  function automatic int unsigned bitcnt_width(input int unsigned width);
    return cnt_width(width - 32'd1);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nrzi_unstuff.sv
// NRZI decoder and bit unstuffer.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   en            sample strobe for i
//   i             NRZI line level
//   clr           framing clear (restarts the ones run)
//   bit_s         decoded bit (no transition = 1)
//   bit_ok_s      decoded bit is a data bit to be kept (qualified by en, ~clr)
//   stuff_err_s   decoded bit broke the stuffing rule (qualified by en, ~clr)
module gf180mcu_fd_sc_mcu7t5v0__nrzi_unstuff
  import gf180mcu_fd_sc_mcu7t5v0__nrzi_pkg::*;
#(
  parameter int unsigned STUFF_LEN = STUFF_LEN_DEF,
  parameter logic        IDLE_LVL  = IDLE_LVL_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic i,
  input  logic clr,
  output logic bit_s,
  output logic bit_ok_s,
  output logic stuff_err_s
);

  localparam int unsigned OW = ones_width(STUFF_LEN);

  logic          prev_r;
  logic [OW-1:0] ones_r;
  logic          run_full_s;

  assign bit_s      = ~(i ^ prev_r);
  assign run_full_s = (ones_r == OW'(STUFF_LEN));

  // Classify the current sample: kept data bit, silently dropped stuff bit, or violation.
  always_comb begin
    bit_ok_s    = 1'b0;
    stuff_err_s = 1'b0;
    if (en && !clr) begin
      if (run_full_s) begin
        stuff_err_s = bit_s;
      end else begin
        bit_ok_s = 1'b1;
      end
    end else begin
      bit_ok_s    = 1'b0;
      stuff_err_s = 1'b0;
    end
  end

  // Previous line level and consecutive-ones run tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r <= IDLE_LVL;
      ones_r <= '0;
    end else begin
      // The line level is tracked even during a clear so decoding stays in phase.
      if (en) begin
        prev_r <= i;
      end
      if (clr || (en && run_full_s)) begin
        ones_r <= '0;
      end else if (en) begin
        ones_r <= bit_s ? (ones_r + OW'(1)) : '0;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nrzi_rx8.sv
// NRZI serial receiver: decodes the line, removes stuffed bits, and
// deserialises LSB-first into WIDTH-bit words.
// Ports:
//   CLK, RST   clock and synchronous active-high reset
//   EN         sample strobe; I is sampled only when EN=1
//   I          NRZI line, already synchronised to CLK
//   CLR        framing clear (realign to word boundary)
//   Q          last completed word, LSB = first received bit
//   VLD        one-cycle pulse when Q holds a new word
//   ERR        one-cycle pulse on a stuffing violation
//   VDD, VSS   supply pins, carried through only
module gf180mcu_fd_sc_mcu7t5v0__nrzi_rx8
  import gf180mcu_fd_sc_mcu7t5v0__nrzi_pkg::*;
#(
  parameter int unsigned WIDTH     = 32'd8,
  parameter int unsigned STUFF_LEN = STUFF_LEN_DEF,
  parameter logic        IDLE_LVL  = IDLE_LVL_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             I,
  input  logic             CLR,
  output logic [WIDTH-1:0] Q,
  output logic             VLD,
  output logic             ERR,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam int unsigned BW = bitcnt_width(WIDTH);

  logic             bit_s;
  logic             bit_ok_s;
  logic             stuff_err_s;
  logic [WIDTH-1:0] shreg_r;
  logic [BW-1:0]    bitcnt_r;
  logic [WIDTH-1:0] word_s;
  logic [WIDTH-1:0] q_r;
  logic             vld_r;
  logic             err_r;
  logic             unused_supply_s;

  assign unused_supply_s = VDD ^ VSS;

  gf180mcu_fd_sc_mcu7t5v0__nrzi_unstuff #(
    .STUFF_LEN (STUFF_LEN),
    .IDLE_LVL  (IDLE_LVL)
  ) u_unstuff (
    .clk         (CLK),
    .rst         (RST),
    .en          (EN),
    .i           (I),
    .clr         (CLR),
    .bit_s       (bit_s),
    .bit_ok_s    (bit_ok_s),
    .stuff_err_s (stuff_err_s)
  );

  // Word as it stands once the current bit is placed, so Q updates on the last bit's edge.
  always_comb begin
    word_s           = shreg_r;
    word_s[bitcnt_r] = bit_s;
  end

  // Shift register, bit counter and registered Q/VLD/ERR.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg_r  <= '0;
      bitcnt_r <= '0;
      q_r      <= '0;
      vld_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      vld_r <= 1'b0;
      err_r <= 1'b0;
      if (CLR) begin
        shreg_r  <= '0;
        bitcnt_r <= '0;
      end else if (stuff_err_s) begin
        // A violation also wins on the would-be last bit: no word is emitted.
        err_r    <= 1'b1;
        shreg_r  <= '0;
        bitcnt_r <= '0;
      end else if (bit_ok_s) begin
        if (bitcnt_r == BW'(WIDTH - 32'd1)) begin
          q_r      <= word_s;
          vld_r    <= 1'b1;
          shreg_r  <= '0;
          bitcnt_r <= '0;
        end else begin
          shreg_r  <= word_s;
          bitcnt_r <= bitcnt_r + BW'(1);
        end
      end
    end
  end

  assign Q   = q_r;
  assign VLD = vld_r;
  assign ERR = err_r;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__nrzi_rx8.sv
// Directed self-checking bench for the NRZI receiver.
module tb_gf180mcu_fd_sc_mcu7t5v0__nrzi_rx8;

  logic       clk;
  logic       rst;
  logic       en;
  logic       i;
  logic       clr;
  logic [7:0] q;
  logic       vld;
  logic       err;
  wire        vdd;
  wire        vss;

  int checks;
  int errors;
  logic line;   // line level the receiver last sampled

  assign vdd = 1'b1;
  assign vss = 1'b0;

  gf180mcu_fd_sc_mcu7t5v0__nrzi_rx8 dut (
    .CLK (clk),
    .RST (rst),
    .EN  (en),
    .I   (i),
    .CLR (clr),
    .Q   (q),
    .VLD (vld),
    .ERR (err),
    .VDD (vdd),
    .VSS (vss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1ns after the edge.
  task automatic step(input logic r, input logic e, input logic d, input logic c);
    rst = r; en = e; i = d; clr = c;
    @(posedge clk);
    #1;
  endtask

  // Send one decoded bit as an NRZI level.
  task automatic send_bit(input logic d);
    line = d ? line : ~line;
    step(1'b0, 1'b1, line, 1'b0);
  endtask

  // Send n decoded bits LSB-first; VLD expected only after bit vld_at; gaps idle cycles between bits.
  task automatic send_bits(input string tag, input logic [15:0] bits, input int n,
                           input int vld_at, input int gaps);
    for (int k = 0; k < n; k++) begin
      send_bit(bits[k]);
      chk({tag, "_vld"}, 32'(vld), 32'(k == vld_at));
      chk({tag, "_err"}, 32'(err), 32'd0);
      for (int g = 0; g < gaps; g++) begin
        step(1'b0, 1'b0, ~line, 1'b0);
        chk({tag, "_gapvld"}, 32'(vld), 32'd0);
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    line = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    line   = 1'b1;
    rst = 1'b1; en = 1'b0; i = 1'b1; clr = 1'b0;

    // 1: reset
    do_reset(2);
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // 2: zero word (line toggles every sample)
    send_bits("zero", 16'h0000, 8, 7, 0);
    chk("zero_q", 32'(q), 32'h00);
    step(1'b0, 1'b0, line, 1'b0);
    chk("zero_vld_drop", 32'(vld), 32'd0);

    // 3: six ones, stuffed zero, then 0,0 -> 0x3F
    send_bits("stuff", 16'b0_0000_0011_1111, 9, 8, 0);
    chk("stuff_q", 32'(q), 32'h3F);

    // 5: 0xA5 with three idle cycles between samples; Q keeps 0x3F meanwhile
    send_bits("gap", 16'h00A5, 7, -1, 3);
    chk("gap_q_hold", 32'(q), 32'h3F);
    send_bits("gap_last", 16'h0001, 1, 0, 3);
    chk("gap_q", 32'(q), 32'hA5);

    // 4: violation from reset, then 0xA5
    do_reset(1);
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("viol_err", 32'(err), 32'(k == 6));
      chk("viol_vld", 32'(vld), 32'd0);
    end
    send_bits("viol_word", 16'h00A5, 8, 7, 0);
    chk("viol_q", 32'(q), 32'hA5);

    // 6a: four bits then RST, then 0x5A
    send_bits("abort_rst_pre", 16'h000B, 4, -1, 0);
    do_reset(1);
    chk("abort_rst_q0", 32'(q), 32'h00);
    send_bits("abort_rst", 16'h005A, 8, 7, 0);
    chk("abort_rst_q", 32'(q), 32'h5A);

    // 6b: four bits then CLR with EN=1 (line transition absorbed), then 0x5A
    q_hold_dummy();
    send_bits("abort_clr_pre", 16'h000F, 4, -1, 0);
    line = ~line;
    step(1'b0, 1'b1, line, 1'b1);
    chk("abort_clr_vld", 32'(vld), 32'd0);
    chk("abort_clr_err", 32'(err), 32'd0);
    chk("abort_clr_qhold", 32'(q), 32'h5A);
    send_bits("abort_clr", 16'h005A, 8, 7, 0);
    chk("abort_clr_q", 32'(q), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // One idle cycle between the two abort scenarios.
  task automatic q_hold_dummy();
    step(1'b0, 1'b0, line, 1'b0);
    chk("idle_vld", 32'(vld), 32'd0);
  endtask

endmodule
